// File: rtl/control_mult_seq.sv
// -----------------------------------------------------------------------------
// control_mult_seq
//
// Control FSM for an iterative shift-and-add multiplier datapath. A rising
// edge on init loads the operands and clears the accumulator. For each of
// WIDTH iterations the FSM tests the multiplier LSB, optionally adds the
// multiplicand to the accumulator, and then shifts. When the iterations are
// finished, done is held high for DONE_CYCLES cycles and the FSM returns to
// idle.
//
// Optional feature: define CONTROL_MULT_EARLY_EXIT_EN to finish as soon as
// the multiplier register becomes zero. The zero flag is tested in CHECK and
// takes priority over lsb. When the macro is undefined, zero is ignored.
//
// Ports:
//   clk      in   processor clock, rising edge
//   rst      in   synchronous, active-high reset
//   init     in   start request (rising edge only)
//   lsb      in   bit 0 of the multiplier register
//   zero     in   multiplier register is all zeros (early-exit build only)
//   ld       out  load operand registers
//   clr_acc  out  clear accumulator
//   add      out  accumulator += multiplicand
//   sh       out  shift multiplicand left, multiplier right
//   busy     out  operation in progress
//   done     out  result valid
//   iter     out  number of shifts completed
// -----------------------------------------------------------------------------
module control_mult_seq #(
    parameter int WIDTH       = 16,
    parameter int DONE_CYCLES = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         init,
    input  logic                         lsb,
    input  logic                         zero,
    output logic                         ld,
    output logic                         clr_acc,
    output logic                         add,
    output logic                         sh,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WIDTH+1)-1:0]   iter
);

    localparam int IW = $clog2(WIDTH + 1);
    localparam int CW = $clog2(DONE_CYCLES + 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(WIDTH - 1);
    localparam logic [CW-1:0] DONE_LAST = CW'(DONE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_END   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic [CW-1:0]   done_cnt_q, done_cnt_d;
    logic            init_q;
    logic            start_s;

    // A start request is only the first cycle of init being high.
    assign start_s = init & ~init_q;

`ifndef CONTROL_MULT_EARLY_EXIT_EN
    // The zero flag has no role when the feature is disabled.
    logic zero_unused_s;
    assign zero_unused_s = zero;
`endif

    // State, iteration counter, done-hold counter and init edge register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            iter_q     <= '0;
            done_cnt_q <= '0;
            init_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            done_cnt_q <= done_cnt_d;
            init_q     <= init;
        end
    end

    // Next-state logic and counter updates
    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        done_cnt_d = done_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                iter_d  = '0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
`ifdef CONTROL_MULT_EARLY_EXIT_EN
                // All remaining bits are zero, so further iterations add nothing.
                if (zero) begin
                    state_d = S_END;
                end else if (lsb) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHIFT;
                end
`else
                if (lsb) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHIFT;
                end
`endif
            end
            S_ADD: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                iter_d = iter_q + IW'(1);
                // Compare before the increment so iter never exceeds WIDTH.
                if (iter_q == ITER_LAST) begin
                    state_d = S_END;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_END: begin
                if (done_cnt_q == DONE_LAST) begin
                    done_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    done_cnt_d = done_cnt_q + CW'(1);
                    state_d    = S_END;
                end
            end
            default: begin
                done_cnt_d = '0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // Moore output decode from the state register only
    always_comb begin
        ld      = 1'b0;
        clr_acc = 1'b0;
        add     = 1'b0;
        sh      = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_LOAD: begin
                ld      = 1'b1;
                clr_acc = 1'b1;
                busy    = 1'b1;
            end
            S_CHECK: begin
                busy = 1'b1;
            end
            S_ADD: begin
                add  = 1'b1;
                busy = 1'b1;
            end
            S_SHIFT: begin
                sh   = 1'b1;
                busy = 1'b1;
            end
            S_END: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign iter = iter_q;

endmodule

// File: tb/tb_control_mult_seq.sv
// -----------------------------------------------------------------------------
// Self-checking bench for control_mult_seq (WIDTH=8, DONE_CYCLES=4).
// A small datapath model supplies lsb/zero from a multiplier shift register
// driven by ld/sh. Expected pulse counts, latency and final iter come from
// arithmetic on the multiplier value.
// -----------------------------------------------------------------------------
module tb_control_mult_seq;

    localparam int W  = 8;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       init;
    logic       lsb;
    logic       zero;
    logic       ld, clr_acc, add, sh, busy, done;
    logic [3:0] iter;

    logic [7:0] operand = 8'd0;
    logic [7:0] mreg    = 8'd0;

    int errors = 0;
    int checks = 0;

    int n_ld, n_clr, n_add, n_sh, ld_cyc, end_cyc, done_len, end_iter;
    int misalign, busy_bad, timed_out;

    control_mult_seq #(.WIDTH(W), .DONE_CYCLES(DC)) dut (
        .clk     (clk),
        .rst     (rst),
        .init    (init),
        .lsb     (lsb),
        .zero    (zero),
        .ld      (ld),
        .clr_acc (clr_acc),
        .add     (add),
        .sh      (sh),
        .busy    (busy),
        .done    (done),
        .iter    (iter)
    );

    always #5 clk = ~clk;

    // Multiplier register of the datapath
    always @(posedge clk) begin
        if (ld) mreg <= operand;
        else if (sh) mreg <= mreg >> 1;
    end
    assign lsb  = mreg[0];
    assign zero = (mreg == 8'd0);

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected adds, iterations and LOAD-to-END latency for a multiplier
    function automatic void model(input logic [7:0] m, output int p, output int k, output int lat);
        p = $countones(m);
`ifdef CONTROL_MULT_EARLY_EXIT_EN
        k = 0;
        for (int b = 0; b < W; b++) if (m[b]) k = b + 1;
        lat = (k == W) ? (1 + 2 * W + p) : (2 + 2 * k + p);
`else
        k   = W;
        lat = 1 + 2 * W + p;
`endif
    endfunction

    // Watch one operation from the cycle after init rises until done falls
    task automatic observe(input int hold, input int poke);
        int poked;
        poked = 0;
        n_ld = 0; n_clr = 0; n_add = 0; n_sh = 0;
        ld_cyc = -1; end_cyc = -1; done_len = 0; end_iter = -1;
        misalign = 0; busy_bad = 0; timed_out = 1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0 && hold == 0) init = 1'b0;
            if (poke == 1 && sh && poked == 0) begin
                init  = 1'b1;
                poked = 1;
            end else if (poked == 1) begin
                init  = 1'b0;
                poked = 2;
            end
            if (ld) begin
                n_ld++;
                if (ld_cyc < 0) ld_cyc = c;
            end
            if (clr_acc) n_clr++;
            if (add) begin
                n_add++;
                if (!lsb) misalign++;
            end
            if (sh) n_sh++;
            if (ld_cyc >= 0 && end_cyc < 0 && !done && !busy) busy_bad++;
            if (done) begin
                if (busy) busy_bad++;
                if (end_cyc < 0) begin
                    end_cyc  = c;
                    end_iter = int'(iter);
                end
                done_len++;
            end else if (end_cyc >= 0) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [7:0] m, input int hold, input int poke, input string tag);
        int p, k, lat;
        operand = m;
        @(negedge clk);
        init = 1'b1;
        observe(hold, poke);
        model(m, p, k, lat);
        chk({tag, ".timeout"}, timed_out, 0);
        chk({tag, ".ld_lat"}, ld_cyc, 0);
        chk({tag, ".ld"}, n_ld, 1);
        chk({tag, ".clr_acc"}, n_clr, 1);
        chk({tag, ".add"}, n_add, p);
        chk({tag, ".add_align"}, misalign, 0);
        chk({tag, ".sh"}, n_sh, k);
        chk({tag, ".end_lat"}, end_cyc - ld_cyc, lat);
        chk({tag, ".done_len"}, done_len, DC);
        chk({tag, ".iter_end"}, end_iter, k);
        chk({tag, ".busy"}, busy_bad, 0);
        chk({tag, ".iter_hold"}, int'(iter), k);
    endtask

    // n idle cycles in which no control output may be active
    task automatic quiet(input int n, input string tag);
        int act;
        act = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            act += int'(ld) + int'(clr_acc) + int'(add) + int'(sh) + int'(busy) + int'(done);
        end
        chk({tag, ".quiet"}, act, 0);
    endtask

    initial begin
        int found;
        rst  = 1'b1;
        init = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and idle
        chk("reset.iter", int'(iter), 0);
        quiet(10, "reset");
        chk("reset.iter_idle", int'(iter), 0);

        // Single pulse, mixed multiplier
        run_op(8'hA5, 0, 0, "a5");
        quiet(5, "a5_after");

        // init held high: one operation only
        run_op(8'hFF, 1, 0, "ff_held");
        quiet(10, "held_high");
        init = 1'b0;
        @(negedge clk);
        run_op(8'hFF, 0, 0, "ff_again");

        // Reset in ADD of iteration 3
        operand = 8'hFF;
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init  = 1'b0;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (add && iter == 4'd3) begin
                found = 1;
                break;
            end
        end
        chk("rst_mid.reach_add3", found, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.outputs", int'({ld, clr_acc, add, sh, busy, done}), 0);
        chk("rst_mid.iter", int'(iter), 0);
        quiet(5, "rst_mid");
        run_op(8'h01, 0, 0, "after_rst");

        // init pulse during SHIFT is ignored, no spurious LOAD afterwards
        run_op(8'h5A, 0, 1, "poke");
        quiet(10, "poke_after");

        // Early-exit relevant patterns (full run when the feature is off)
        run_op(8'h03, 0, 0, "m03");
        run_op(8'h00, 0, 0, "m00");
        run_op(8'h80, 0, 0, "m80");

        // Random multipliers
        for (int r = 0; r < 6; r++) begin
            run_op(8'($urandom_range(0, 255)), 0, 0, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
